arb_mux_pipe: RTL and testbench
===============================

ARB_MUX_PIPE -- requirements
Module: arb_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits.
REQ-002 Parameter N, default 4, input channel count, N >= 2; SW = clog2(N).
REQ-003 Parameter MODE, default 0: 0 = select-driven channel choice, 1 = round-robin arbitration.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset is synchronous and active-high.
REQ-006 in_valid  input  N  per-channel data-valid.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-009 sel  input  SW  channel index used in MODE 0; ignored in MODE 1.
REQ-010 out_valid  output  1  output register holds valid data.
REQ-011 out_data  output  WIDTH  registered data of accepted channel.
REQ-012 out_src  output  SW  index of channel whose data is in out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both high; an output transfer SHALL occur where out_valid and out_ready are both high.
REQ-015 load_en SHALL equal (!out_valid || out_ready); in_ready SHALL be all-zero when load_en is low.
REQ-016 MODE 0: in_ready[i] SHALL be high only for i == sel and load_en high, independent of in_valid; sel >= N SHALL grant no channel.
REQ-017 MODE 1: grant SHALL go to the first channel with in_valid high, searching from ptr upward with wrap from N-1 to 0; in_ready[grant] SHALL be high only when load_en is high and some in_valid is high.
REQ-018 MODE 1: after each input transfer on channel g, ptr SHALL become (g+1) mod N; ptr SHALL hold otherwise.
REQ-019 Latency SHALL be exactly 1 cycle: data accepted at edge k appears on out_data/out_src with out_valid high after edge k.
REQ-020 While out_valid && !out_ready, out_data and out_src SHALL hold stable and no input SHALL be accepted.
REQ-021 Simultaneous output transfer and input transfer SHALL replace the register contents, keeping out_valid high (1 transfer/cycle throughput).
REQ-022 Output transfer with no input transfer SHALL clear out_valid; out_data and out_src SHALL retain last values.
REQ-023 in_ready SHALL be combinational from in_valid (MODE 1), sel (MODE 0), out_valid, out_ready and ptr; out_* SHALL be registered only.

Reset
REQ-024 On rst high at a rising edge: out_valid = 0, out_data = 0, out_src = 0, ptr = 0, regardless of any in-flight transfer.
REQ-025 While rst is high, in_ready SHALL be all-zero and no transfer SHALL be recorded.

Structure
REQ-026 Mode encodings (MODE_SEL = 0, MODE_RR = 1) SHALL live in the shared project constants header/package; WIDTH/N defaults stay local parameters.
REQ-027 Round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs req[N], ptr; output grant index and grant_valid); the output register stays in arb_mux_pipe.

Verification
REQ-028 MODE 0, N=4, WIDTH=32: sel=2, in_data ch2=100, all valid, out_ready=1 -> next cycle out_valid=1, out_data=100, out_src=2; in_ready=4'b0100.
REQ-029 MODE 0 backpressure: out_valid=1 holding 200, out_ready=0, sel changes 2->1 -> in_ready=0, out_data stays 200 for 3 cycles; out_ready=1 -> ch1 data loaded next cycle.
REQ-030 MODE 1, all four channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, out_valid constantly high.
REQ-031 MODE 1 wrap/skip: ptr=3, only ch1 valid (data 50) -> grant ch1, out_data=50, ptr becomes 2; next only ch0 and ch3 valid -> ch3 granted first.
REQ-032 Reset mid-operation: out_valid=1, out_data=100, assert rst one cycle -> out_valid=0, out_data=0, out_src=0; MODE 1 next grant starts search at ch0.
REQ-033 Drain: out_valid=1, out_ready=1, no in_valid -> out_valid=0 next cycle, out_data unchanged.

Source files
------------

// File: rtl/arb_mux_pipe_pkg.sv
// Shared constants for the arbitrated mux pipeline: channel-selection mode encodings and index helper.
package arb_mux_pipe_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_mux_pipe_rr_arbiter.sv
// Round-robin grant: first requesting channel at or above ptr, wrapping N-1 -> 0.
// Purely combinational; no state, so the caller owns the pointer.
module rr_arbiter import arb_mux_pipe_pkg::*; #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant       = SW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_pipe.sv
// N-to-1 channel mux (select-driven or round-robin) into a single output register.
// Latency 1 cycle; inputs stall while the held output is not accepted, full throughput otherwise.
module arb_mux_pipe import arb_mux_pipe_pkg::*; #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    input  logic               out_ready
);

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    rr_grant;
    logic             rr_grant_vld;
    logic [SW-1:0]    chan;
    logic [WIDTH-1:0] chan_data;
    logic             load_en;
    logic             in_xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_src_q, out_src_d;

    rr_arbiter #(.N(N)) u_rr (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (rr_grant),
        .grant_valid (rr_grant_vld)
    );

    always_comb begin
        load_en   = !rst && (!out_valid_q || out_ready);
        in_ready  = '0;
        chan      = (MODE == MODE_RR) ? rr_grant : sel;
        chan_data = '0;

        if (load_en) begin
            if (MODE == MODE_RR) begin
                if (rr_grant_vld) in_ready[rr_grant] = 1'b1;
            end else begin
                // Out-of-range sel matches no channel and so grants nothing.
                for (int i = 0; i < N; i++) begin
                    if (sel == SW'(i)) in_ready[i] = 1'b1;
                end
            end
        end

        in_xfer = |(in_ready & in_valid);

        for (int i = 0; i < N; i++) begin
            if (chan == SW'(i)) chan_data = in_data[i*WIDTH +: WIDTH];
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;

        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data;
            out_src_d   = chan;
            if (MODE == MODE_RR) ptr_d = SW'(wrap_inc(int'(chan), N));
        end else if (out_ready) begin
            // Drain: data/src keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_pipe.sv
// Directed bench: one select-mode and one round-robin instance, checked with immediate assertions.
module tb_arb_mux_pipe;
    import arb_mux_pipe_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic clk, rst;

    logic [N-1:0]   iv0, ir0, iv1, ir1;
    logic [N*W-1:0] id0, id1;
    logic [1:0]     sel0, sel1, os0, os1;
    logic           ov0, ov1, ordy0, ordy1;
    logic [W-1:0]   od0, od1;

    int checks   = 0;
    int failures = 0;

    arb_mux_pipe #(.WIDTH(W), .N(N), .MODE(MODE_SEL)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
        .sel(sel0), .out_valid(ov0), .out_data(od0), .out_src(os0), .out_ready(ordy0)
    );

    arb_mux_pipe #(.WIDTH(W), .N(N), .MODE(MODE_RR)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .sel(sel1), .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(ordy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        iv0 = '0; id0 = '0; sel0 = '0; ordy0 = 1'b0;
        iv1 = '0; id1 = '0; sel1 = '0; ordy1 = 1'b0;

        // Reset holds off all grants even with everything requesting.
        @(negedge clk);
        sel0 = 2'd2; iv0 = 4'hF; ordy0 = 1'b1;
        iv1 = 4'hF; ordy1 = 1'b1;
        #1;
        chk("rst_ir0", 32'(ir0), 32'h0);
        chk("rst_ir1", 32'(ir1), 32'h0);
        tick;
        chk("rst_ov0", 32'(ov0), 32'd0);
        chk("rst_od0", od0, 32'd0);
        chk("rst_os0", 32'(os0), 32'd0);
        chk("rst_ov1", 32'(ov1), 32'd0);
        iv1 = '0;
        rst = 1'b0;

        // MODE 0: sel=2, ch2 carries 100.
        id0[0*W +: W] = 32'd10; id0[1*W +: W] = 32'd11;
        id0[2*W +: W] = 32'd100; id0[3*W +: W] = 32'd13;
        #1;
        chk("m0_ir_sel2", 32'(ir0), 32'b0100);
        tick;
        chk("m0_ov", 32'(ov0), 32'd1);
        chk("m0_od", od0, 32'd100);
        chk("m0_os", 32'(os0), 32'd2);

        // Load 200, then stall and change sel.
        id0[2*W +: W] = 32'd200;
        tick;
        chk("m0_od200", od0, 32'd200);
        ordy0 = 1'b0; sel0 = 2'd1; id0[1*W +: W] = 32'd55;
        #1;
        chk("m0_bp_ir", 32'(ir0), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("m0_bp_od", od0, 32'd200);
            chk("m0_bp_os", 32'(os0), 32'd2);
            chk("m0_bp_ov", 32'(ov0), 32'd1);
        end
        ordy0 = 1'b1;
        #1;
        chk("m0_release_ir", 32'(ir0), 32'b0010);
        tick;
        chk("m0_ch1_od", od0, 32'd55);
        chk("m0_ch1_os", 32'(os0), 32'd1);

        // Drain with no valid inputs.
        iv0 = '0;
        tick;
        chk("m0_drain_ov", 32'(ov0), 32'd0);
        chk("m0_drain_od", od0, 32'd55);
        chk("m0_drain_os", 32'(os0), 32'd1);

        // MODE 1: all valid, rotation 0,1,2,3,0,1,2 -> ptr ends at 3.
        for (int i = 0; i < N; i++) id1[i*W +: W] = 32'(16 + i);
        iv1 = 4'hF; ordy1 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("m1_rr_ir", 32'(ir1), 32'(1 << (k % 4)));
            tick;
            chk("m1_rr_ov", 32'(ov1), 32'd1);
            chk("m1_rr_os", 32'(os1), 32'(k % 4));
            chk("m1_rr_od", od1, 32'(16 + k % 4));
        end

        // ptr=3, only ch1 valid -> ch1 granted, ptr becomes 2.
        iv1 = 4'b0010; id1[1*W +: W] = 32'd50;
        #1;
        chk("m1_skip_ir", 32'(ir1), 32'b0010);
        tick;
        chk("m1_skip_od", od1, 32'd50);
        chk("m1_skip_os", 32'(os1), 32'd1);
        // From ptr=2 with ch0 and ch3 valid, ch3 wins.
        iv1 = 4'b1001;
        #1;
        chk("m1_wrap_ir", 32'(ir1), 32'b1000);
        tick;
        chk("m1_wrap_os", 32'(os1), 32'd3);
        chk("m1_wrap_od", od1, 32'd19);

        // ptr=0 now; load ch2=100 to leave ptr at 3 before reset.
        iv1 = 4'b0100; id1[2*W +: W] = 32'd100;
        tick;
        chk("m1_pre_rst_od", od1, 32'd100);
        chk("m1_pre_rst_os", 32'(os1), 32'd2);
        rst = 1'b1; iv1 = 4'hF;
        #1;
        chk("m1_rst_ir", 32'(ir1), 32'h0);
        tick;
        chk("m1_rst_ov", 32'(ov1), 32'd0);
        chk("m1_rst_od", od1, 32'd0);
        chk("m1_rst_os", 32'(os1), 32'd0);
        rst = 1'b0;
        #1;
        chk("m1_post_rst_ir", 32'(ir1), 32'b0001);
        tick;
        chk("m1_post_rst_os", 32'(os1), 32'd0);
        chk("m1_post_rst_od", od1, 32'd16);

        // Backpressure in round-robin mode.
        ordy1 = 1'b0;
        #1;
        chk("m1_bp_ir", 32'(ir1), 32'h0);
        tick;
        chk("m1_bp_os", 32'(os1), 32'd0);
        chk("m1_bp_od", od1, 32'd16);

        // Drain, then idle with nothing requesting.
        ordy1 = 1'b1; iv1 = '0;
        #1;
        chk("m1_idle_ir", 32'(ir1), 32'h0);
        tick;
        chk("m1_drain_ov", 32'(ov1), 32'd0);
        chk("m1_drain_od", od1, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
